lcd_refresh_ctrl: RTL and testbench
===================================

LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 750000, meaning the power-up wait in clocks (15 ms at 50 MHz).
REQ-002 SHALL have parameter EN_CYC, default 25, meaning the LCD_EN high width in clocks.
REQ-003 SHALL have parameter CMD_CYC, default 2500, meaning the post-byte wait in clocks for every byte except clear.
REQ-004 SHALL have parameter CLR_CYC, default 100000, meaning the post-byte wait in clocks after the clear command 0x01.
REQ-005 SHALL have port CLOCK_50  input  1  system clock; every register samples on its rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  character-buffer write strobe.
REQ-008 SHALL have port wr_addr  input  5  buffer index: 0-15 = line 1, 16-31 = line 2.
REQ-009 SHALL have port wr_data  input  8  ASCII character to store.
REQ-010 SHALL have port LCD_EN  output  1  HD44780 enable strobe.
REQ-011 SHALL have port LCD_RS  output  1  0 = command byte, 1 = data byte.
REQ-012 SHALL have port LCD_RW  output  1  read/write select; constant 0 (write-only).
REQ-013 SHALL have port LCD_DATA  output  8  byte presented to the LCD.
REQ-014 SHALL have port init_done  output  1  high once the init sequence has completed.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at the end of each 32-character refresh.

Function
REQ-016 SHALL hold a 32x8 character buffer; when wr_en=1 it writes wr_data to wr_addr on the clock edge, in any state.
REQ-017 SHALL send every byte as one transfer with this timing:
- SETUP: 2 cycles, EN=0, RS/DATA valid.
- STROBE: EN_CYC cycles with EN=1.
- WAIT: CMD_CYC cycles with EN=0, or CLR_CYC cycles for byte 0x01.
REQ-018 SHALL keep RS and DATA constant from the first SETUP cycle through the last WAIT cycle of a transfer.
REQ-019 SHALL change RS and DATA only in the cycle that enters SETUP.
REQ-020 SHALL use these states: PWRUP, INIT, ADDR1, LINE1, ADDR2, LINE2.
REQ-021 PWRUP SHALL hold EN=0 for PWRUP_CYC cycles after reset release, then go to INIT.
REQ-022 INIT SHALL send commands (RS=0) 0x38, 0x0C, 0x06, 0x01, in that order.
REQ-023 SHALL set init_done on the cycle after the last CLR_CYC wait cycle and hold it at 1 until reset.
REQ-024 ADDR1 SHALL send command 0x80, then go to LINE1.
REQ-025 LINE1 SHALL send buffer[0..15] as data (RS=1), in ascending order.
REQ-026 ADDR2 SHALL send command 0xC0, then go to LINE2.
REQ-027 LINE2 SHALL send buffer[16..31] as data (RS=1), in ascending order.
REQ-028 At the end of the last LINE2 WAIT, SHALL pulse frame_done for exactly 1 cycle.
REQ-029 The cycle after the frame_done pulse SHALL start the ADDR1 SETUP with no idle gap, and the refresh SHALL repeat indefinitely.
REQ-030 SHALL capture a character into DATA at the edge entering its SETUP, using buffer contents from before that edge.
REQ-031 A same-cycle wr_en to that same address SHALL appear on the next frame, not the current one.
REQ-032 Writes during an active transfer SHALL NOT alter LCD_DATA.
REQ-033 SHALL size all delay counters for max(PWRUP_CYC, CLR_CYC); the character index SHALL wrap 15->0 between lines.
REQ-034 SHALL drive LCD_RW to 0 in all states.

Reset
REQ-035 While RESET=1, SHALL hold LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, init_done=0, frame_done=0, state=PWRUP, all counters=0, and every buffer entry=0x20.
REQ-036 If RESET asserts mid-transfer, SHALL force LCD_EN to 0 immediately (asynchronously).
REQ-037 After RESET releases, SHALL restart with the full PWRUP wait.

Verification (PWRUP_CYC=20, EN_CYC=4, CMD_CYC=10, CLR_CYC=30)
REQ-038 Check the init timing:
- Stimulus: release RESET.
- Response: EN=0 for 20 cycles.
- Then the first EN rise occurs 2 cycles later with DATA=0x38, RS=0, EN high for 4 cycles.
- Then 0x0C, 0x06, 0x01 follow, each 16 cycles after the previous one.
- init_done rises 36 cycles after 0x01 enters SETUP.
REQ-039 Check the line-1 refresh:
- Stimulus: write "HELLO" to addresses 0-4, then run one frame.
- Response: 0x80 (RS=0), then 0x48 0x45 0x4C 0x4C 0x4F (RS=1), then eleven 0x20.
REQ-040 Check the line-2 refresh and frame timing:
- Stimulus: write 0x31 to address 16.
- Response: the LINE2 first byte is 0x31, sent after 0xC0 (RS=0).
- frame_done pulses once per 34 transfers (34x16 = 544 cycles).
REQ-041 Check the write/fetch collision:
- Stimulus: write 0x41 to address 3 in the same cycle that char 3 enters SETUP.
- Response: 0x20 goes out in that frame and 0x41 in the next; DATA stays stable while EN=1.
REQ-042 Check reset during STROBE:
- Stimulus: assert RESET while EN=1 during LINE1.
- Response: EN=0 the same cycle, outputs at reset values, buffer all 0x20.
- After release, the full 20-cycle PWRUP wait runs, then 0x38 is sent.
REQ-043 Check the LCD_RW and strobe invariants over 3 full frames:
- LCD_RW is never 1.
- EN pulses are exactly 4 cycles wide.
- RS/DATA never change while EN=1 or during WAIT.

Source files
------------

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 refresh controller: power-up wait, 4-command init, then an endless
// refresh of a 32-character buffer (line 1 at 0x80, line 2 at 0xC0).
module lcd_refresh_ctrl #(
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 25,
  parameter int CMD_CYC   = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       init_done,
  output logic       frame_done,
  output logic [2:0] dbg_state,
  output logic [1:0] dbg_phase
);

  localparam int MAX_CYC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_LINE1 = 3'd3,
    ST_ADDR2 = 3'd4,
    ST_LINE2 = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_STROBE = 2'd1,
    PH_WAIT   = 2'd2
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          init_done_q, init_done_d;
  logic [7:0]    char_q [32];
  logic [3:0]    idx_nx;
  logic [CW-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h06;
      default: cmd = 8'h01;
    endcase
    return cmd;
  endfunction

  assign idx_nx    = idx_q + 4'd1;
  // Only the clear command gets the long settle time.
  assign wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

  // Character reads below see pre-edge buffer contents, so a write landing
  // on the fetch edge shows up in the following frame.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q + CNT_ONE;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    if (state_q == ST_PWRUP) begin
      if (cnt_q == PWRUP_LAST) begin
        state_d = ST_INIT;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
        rs_d    = 1'b0;
        data_d  = init_cmd(2'd0);
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          if (cnt_q == CNT_ONE) begin
            phase_d = PH_STROBE;
            cnt_d   = '0;
          end
        end
        PH_STROBE: begin
          if (cnt_q == EN_LAST) begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_last) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            idx_d   = idx_nx;
            case (state_q)
              ST_INIT: begin
                rs_d = 1'b0;
                if (idx_q == 4'd3) begin
                  state_d     = ST_ADDR1;
                  idx_d       = '0;
                  data_d      = 8'h80;
                  init_done_d = 1'b1;
                end else begin
                  data_d = init_cmd(idx_nx[1:0]);
                end
              end
              ST_ADDR1: begin
                state_d = ST_LINE1;
                idx_d   = '0;
                rs_d    = 1'b1;
                data_d  = char_q[5'd0];
              end
              ST_LINE1: begin
                if (idx_q == 4'd15) begin
                  state_d = ST_ADDR2;
                  idx_d   = '0;
                  rs_d    = 1'b0;
                  data_d  = 8'hC0;
                end else begin
                  data_d = char_q[{1'b0, idx_nx}];
                end
              end
              ST_ADDR2: begin
                state_d = ST_LINE2;
                idx_d   = '0;
                rs_d    = 1'b1;
                data_d  = char_q[5'd16];
              end
              ST_LINE2: begin
                if (idx_q == 4'd15) begin
                  state_d = ST_ADDR1;
                  idx_d   = '0;
                  rs_d    = 1'b0;
                  data_d  = 8'h80;
                end else begin
                  data_d = char_q[{1'b1, idx_nx}];
                end
              end
              default: state_d = ST_PWRUP;
            endcase
          end
        end
        default: phase_d = PH_SETUP;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_PWRUP;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) char_q[i] <= 8'h20;
    end else if (wr_en) begin
      char_q[wr_addr] <= wr_data;
    end
  end

  // EN decodes straight from flops so an asynchronous reset drops it at once.
  assign LCD_EN     = (state_q != ST_PWRUP) && (phase_q == PH_STROBE);
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = data_q;
  assign init_done  = init_done_q;
  assign frame_done = (state_q == ST_LINE2) && (phase_q == PH_WAIT) &&
                      (idx_q == 4'd15) && (cnt_q == wait_last);
  assign dbg_state  = state_q;
  assign dbg_phase  = phase_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with short timing parameters; transfers
// are captured at each EN rise and compared against hand-computed frames.
module tb_lcd_refresh_ctrl;

  localparam int PWRUP_CYC = 20;
  localparam int EN_CYC    = 4;
  localparam int CMD_CYC   = 10;
  localparam int CLR_CYC   = 30;

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_LINE1 = 3'd3;
  localparam logic [1:0] P_SETUP = 2'd0;
  localparam logic [1:0] P_WAIT  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       lcd_en, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0] lcd_data;
  logic [2:0] dbg_state;
  logic [1:0] dbg_phase;

  lcd_refresh_ctrl #(
    .PWRUP_CYC(PWRUP_CYC), .EN_CYC(EN_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .LCD_EN(lcd_en), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
    .init_done(init_done), .frame_done(frame_done),
    .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] tx_q[$];
  int         tx_cyc_q[$];
  int         fd_q[$];
  logic [8:0] exp_q[$];
  int         id_rise = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: captures transfers and enforces the strobe/stability invariants.
  logic       en_prev = 1'b0, rs_prev = 1'b0, id_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [2:0] state_prev = 3'd0;
  logic [1:0] phase_prev = 2'd0;
  int         en_w = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      if (lcd_en && !en_prev) begin
        tx_q.push_back({lcd_rs, lcd_data});
        tx_cyc_q.push_back(cyc - base);
        en_w = 1;
      end else if (lcd_en) begin
        en_w++;
      end
      if (!lcd_en && en_prev) chk("en_width", en_w, EN_CYC);
      if (lcd_data !== data_prev || lcd_rs !== rs_prev)
        chk("rsdata_change_outside_setup_entry",
            {31'd0, (dbg_phase == P_SETUP) && (phase_prev == P_WAIT || state_prev == S_PWRUP)}, 32'd1);
      if (init_done && !id_prev) id_rise = cyc - base;
      if (frame_done) fd_q.push_back(cyc - base);
    end
    en_prev    = lcd_en;
    rs_prev    = lcd_rs;
    data_prev  = lcd_data;
    id_prev    = init_done;
    state_prev = dbg_state;
    phase_prev = dbg_phase;
  end

  function automatic int exp_rise(input int k);
    return 22 + 16 * k + ((k >= 4) ? 20 : 0);
  endfunction

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("tx_count_reached", {31'd0, tx_q.size() >= n}, 32'd1);
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, {31'd0, lcd_en}, 32'd0);
    chk({tag, "_rs"}, {31'd0, lcd_rs}, 32'd0);
    chk({tag, "_rw"}, {31'd0, lcd_rw}, 32'd0);
    chk({tag, "_data"}, {24'd0, lcd_data}, 32'h00);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_PWRUP});
  endtask

  // Queue one frame: ADDR1, 16 line-1 chars, ADDR2, 16 line-2 chars.
  task automatic push_frame(input logic [7:0] l1[16], input logic [7:0] l2[16]);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
  endtask

  task automatic check_frame(input int k0, input string tag);
    int k = k0;
    while (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, k), {23'd0, tx_q[k]}, {23'd0, e});
      chk($sformatf("%s_cyc%0d", tag, k), tx_cyc_q[k], exp_rise(k));
      k++;
    end
  endtask

  task automatic restart_monitor();
    base = cyc;
    tx_q.delete();
    tx_cyc_q.delete();
    fd_q.delete();
    id_rise = -1;
    mon_en = 1'b1;
  endtask

  logic [7:0] l1[16];
  logic [7:0] l2[16];
  logic [7:0] init_seq[4];
  int         guard;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    init_seq[0] = 8'h38; init_seq[1] = 8'h0C; init_seq[2] = 8'h06; init_seq[3] = 8'h01;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Release and load "HELLO" on line 1 and '1' at line 2 start during PWRUP.
    rst = 1'b0;
    restart_monitor();
    write_buf(5'd0, 8'h48);
    write_buf(5'd1, 8'h45);
    write_buf(5'd2, 8'h4C);
    write_buf(5'd3, 8'h4C);
    write_buf(5'd4, 8'h4F);
    write_buf(5'd16, 8'h31);

    wait_tx(5, 200);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_byte%0d", i), {23'd0, tx_q[i]}, {24'd0, init_seq[i]});
      chk($sformatf("init_cyc%0d", i), tx_cyc_q[i], exp_rise(i));
    end
    chk("init_done_rise", id_rise, 104);

    for (int i = 0; i < 16; i++) begin l1[i] = 8'h20; l2[i] = 8'h20; end
    l1[0] = 8'h48; l1[1] = 8'h45; l1[2] = 8'h4C; l1[3] = 8'h4C; l1[4] = 8'h4F;
    l2[0] = 8'h31;
    wait_tx(73, 1500);
    push_frame(l1, l2);
    check_frame(4, "frame1");
    push_frame(l1, l2);
    exp_q.push_back(9'h080);
    check_frame(38, "frame2");
    chk("frame_done_count", fd_q.size(), 2);
    chk("frame_done_first", fd_q[0], exp_rise(38) - 3);
    chk("frame_done_period", fd_q[1] - fd_q[0], 544);

    // Reset in the middle of a LINE1 strobe.
    guard = 0;
    while (!(lcd_en && dbg_state == S_LINE1) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("found_line1_strobe", {31'd0, lcd_en && dbg_state == S_LINE1}, 32'd1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("held_reset");

    // Restart: buffer back to spaces; collide a write with char 3's fetch edge.
    rst = 1'b0;
    restart_monitor();
    while ((cyc - base) < exp_rise(8) - 3 && (cyc - base) < 1000) @(negedge clk);
    write_buf(5'd3, 8'h41);
    wait_tx(43, 1500);
    chk("restart_byte0", {23'd0, tx_q[0]}, 32'h038);
    chk("restart_cyc0", tx_cyc_q[0], 22);
    for (int i = 0; i < 16; i++) begin l1[i] = 8'h20; l2[i] = 8'h20; end
    push_frame(l1, l2);
    check_frame(4, "cleared_frame");
    chk("collision_next_frame", {23'd0, tx_q[42]}, 32'h141);
    chk("collision_next_cyc", tx_cyc_q[42], exp_rise(42));

    // Let the strobe/stability monitor cover further frames.
    wait_tx(107, 1200);
    chk("long_run_last_addr1", {23'd0, tx_q[106]}, 32'h080);
    chk("long_run_frame_done_count", fd_q.size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
